// File: rtl/instr_exec_unit.sv
// instr_exec_unit
//   Responder end of the instr/instr_en/done instruction handshake. It
//   captures one instruction per handshake and executes it against a
//   2**REG_AW x DATA_W register file. Results appear on data_out1..3.
//
//   Handshake: the feeder raises instr_en with instr valid. The unit captures
//   instr on the first posedge it sees instr_en high while IDLE. done then
//   stays high until the first posedge that sees instr_en low. A request held
//   high across RESP therefore executes only once.
//
// Ports
//   clk        in   1        single clock, all state on posedge
//   rst        in   1        synchronous, active-high reset
//   instr      in   INSTR_W  {opc, rs1, rs2, rd, imm}
//   instr_en   in   1        feeder request; instr valid while high
//   done       out  1        result valid; held until instr_en low
//   busy       out  1        high from capture until return to IDLE
//   data_out1  out  DATA_W   first read result
//   data_out2  out  DATA_W   second read / immediate result
//   data_out3  out  DATA_W   writeback value
module instr_exec_unit #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 5,
  parameter int OPC_W  = 3,
  localparam int INSTR_W = OPC_W + 3 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_en,
  output logic               done,
  output logic               busy,
  output logic [DATA_W-1:0]  data_out1,
  output logic [DATA_W-1:0]  data_out2,
  output logic [DATA_W-1:0]  data_out3
);

  localparam int NUM_REGS = 1 << REG_AW;

  localparam logic [OPC_W-1:0] OP_LI   = 3'b000;
  localparam logic [OPC_W-1:0] OP_RD1  = 3'b001;
  localparam logic [OPC_W-1:0] OP_RD2  = 3'b010;
  localparam logic [OPC_W-1:0] OP_RDI  = 3'b011;
  localparam logic [OPC_W-1:0] OP_CMP  = 3'b100;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b101;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b110;
  localparam logic [OPC_W-1:0] OP_ADDI = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [INSTR_W-1:0] instr_q;
  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  a_q, b_q, imm_q;

  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [DATA_W-1:0] alu_res;
  logic              wr_en;

  // Field decode of the captured instruction only; the live instr bus is
  // ignored after capture.
  assign opc = instr_q[INSTR_W-1 -: OPC_W];
  assign rs1 = instr_q[DATA_W+3*REG_AW-1 -: REG_AW];
  assign rs2 = instr_q[DATA_W+2*REG_AW-1 -: REG_AW];
  assign rd  = instr_q[DATA_W+REG_AW-1 -: REG_AW];

  // The handshake flags come straight from the state, so they cannot
  // disagree with it.
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_RESP);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (instr_en) state_d = S_READ;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_RESP: if (!instr_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- ALU ----------------
  // Arithmetic wraps modulo 2**DATA_W because the result is truncated.
  always_comb begin
    alu_res = '0;
    wr_en   = 1'b0;
    case (opc)
      OP_LI:   begin alu_res = imm_q;       wr_en = 1'b1; end
      OP_CMP:  alu_res = {{(DATA_W-1){1'b0}}, (a_q == b_q)};
      OP_ADD:  begin alu_res = a_q + b_q;   wr_en = 1'b1; end
      OP_SUB:  begin alu_res = a_q - b_q;   wr_en = 1'b1; end
      OP_ADDI: begin alu_res = a_q + imm_q; wr_en = 1'b1; end
      default: begin alu_res = '0;          wr_en = 1'b0; end
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      data_out1 <= '0;
      data_out2 <= '0;
      data_out3 <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (instr_en) instr_q <= instr;
        S_READ: begin
          // R0 reads as zero regardless of array contents.
          a_q   <= (rs1 == '0) ? '0 : regs[rs1];
          b_q   <= (rs2 == '0) ? '0 : regs[rs2];
          imm_q <= instr_q[DATA_W-1:0];
        end
        S_EXEC: begin
          // Operands were latched in READ, so rd == rs1 uses the old value.
          if (wr_en && (rd != '0)) regs[rd] <= alu_res;
          case (opc)
            OP_LI, OP_ADD, OP_SUB, OP_ADDI: data_out3 <= alu_res;
            OP_RD1: data_out1 <= a_q;
            OP_RD2: begin
              data_out1 <= a_q;
              data_out2 <= b_q;
            end
            OP_RDI: begin
              data_out1 <= a_q;
              data_out2 <= imm_q;
            end
            OP_CMP: begin
              data_out1 <= a_q;
              data_out2 <= b_q;
              data_out3 <= alu_res;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit
//   Directed test of instr_exec_unit. Each operation pushes its hand-computed
//   {data_out1, data_out2, data_out3} onto exp_q. A monitor pops one entry on
//   every rising edge of done and compares it with the outputs.
module tb_instr_exec_unit;

  localparam int W = 48;

  logic        clk;
  logic        rst;
  logic [33:0] instr;
  logic        instr_en;
  logic        done;
  logic        busy;
  logic [15:0] data_out1, data_out2, data_out3;

  logic [W-1:0] exp_q[$];
  int compared;
  int mismatched;
  int done_rises;
  logic done_d;

  instr_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .instr_en  (instr_en),
    .done      (done),
    .busy      (busy),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard monitor ----------------
  initial begin
    done_d     = 1'b0;
    done_rises = 0;
  end

  always @(negedge clk) begin
    if (done && !done_d) begin
      done_rises++;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: got %h/%h/%h, required no done pulse",
                 data_out1, data_out2, data_out3);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({data_out1, data_out2, data_out3} !== e) begin
          mismatched++;
          $display("FAIL result: got %h/%h/%h, required %h/%h/%h",
                   data_out1, data_out2, data_out3, e[47:32], e[31:16], e[15:0]);
        end
      end
    end
    done_d = done;
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Issue one op. hold = extra cycles instr_en stays high after done rises.
  task automatic run_op(input logic [2:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [15:0] imm,
                        input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3,
                        input int hold);
    int lat;
    bit got;
    exp_q.push_back({e1, e2, e3});
    @(negedge clk);
    instr    = {opc, rs1, rs2, rd, imm};
    instr_en = 1'b1;
    lat = 0;
    got = 1'b0;
    // Expected: capture edge, operand edge, execute edge -> done after 3 edges.
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (i == 0) instr = {$urandom, $urandom}; // must be ignored after capture
      if (done) got = 1'b1;
    end
    check("done_latency", 16'(lat), got ? 16'd3 : 16'hDEAD);
    repeat (hold) @(negedge clk);
    instr_en = 1'b0;
    for (int i = 0; i < 5 && busy; i++) @(negedge clk);
    check("idle_after_op", {14'b0, busy, done}, 16'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rises0;
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    instr      = {3'b000, 5'd0, 5'd0, 5'd9, 16'h1111};
    instr_en   = 1'b1;

    // 1. reset with a pending request: nothing captured
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_done", {15'b0, done}, 16'd0);
    check("rst_busy", {15'b0, busy}, 16'd0);
    check("rst_do1", data_out1, 16'd0);
    check("rst_do2", data_out2, 16'd0);
    check("rst_do3", data_out3, 16'd0);
    instr_en = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("rst_no_capture", {15'b0, busy}, 16'd0);

    // 2. LI / RD1
    run_op(3'b000, 5'd0, 5'd0, 5'd1, 16'd17,   16'd0,  16'd0, 16'd17, 0);
    run_op(3'b001, 5'd1, 5'd0, 5'd0, 16'd0,    16'd17, 16'd0, 16'd17, 0);
    // 3. arithmetic with negative immediate
    run_op(3'b000, 5'd0, 5'd0, 5'd2, 16'hFFF7, 16'd17, 16'd0, 16'hFFF7, 0);
    run_op(3'b101, 5'd1, 5'd2, 5'd4, 16'd0,    16'd17, 16'd0, 16'd8, 0);
    run_op(3'b110, 5'd1, 5'd2, 5'd5, 16'd0,    16'd17, 16'd0, 16'd26, 0);
    run_op(3'b111, 5'd2, 5'd0, 5'd6, 16'hFFF7, 16'd17, 16'd0, 16'hFFEE, 0);
    run_op(3'b010, 5'd4, 5'd5, 5'd0, 16'd0,    16'd8,  16'd26, 16'hFFEE, 0);
    run_op(3'b011, 5'd5, 5'd0, 5'd0, 16'h1234, 16'd26, 16'h1234, 16'hFFEE, 0);
    run_op(3'b100, 5'd1, 5'd1, 5'd0, 16'd0,    16'd17, 16'd17, 16'd1, 0);
    run_op(3'b100, 5'd1, 5'd2, 5'd0, 16'd0,    16'd17, 16'hFFF7, 16'd0, 0);
    // 4. R0 write discarded
    run_op(3'b000, 5'd0, 5'd0, 5'd0, 16'd5,    16'd17, 16'hFFF7, 16'd5, 0);
    run_op(3'b001, 5'd0, 5'd0, 5'd0, 16'd0,    16'd0,  16'hFFF7, 16'd5, 0);
    // 5. wrap with rd == rs1
    run_op(3'b000, 5'd0, 5'd0, 5'd3, 16'hFFFF, 16'd0,  16'hFFF7, 16'hFFFF, 0);
    run_op(3'b111, 5'd3, 5'd0, 5'd3, 16'd1,    16'd0,  16'hFFF7, 16'd0, 0);
    run_op(3'b001, 5'd3, 5'd0, 5'd0, 16'd0,    16'd0,  16'hFFF7, 16'd0, 0);
    // 6a. held request executes once: R7 = 0x55 + 1 exactly once
    run_op(3'b000, 5'd0, 5'd0, 5'd7, 16'h0055, 16'd0,  16'hFFF7, 16'h0055, 0);
    rises0 = done_rises;
    run_op(3'b111, 5'd7, 5'd0, 5'd7, 16'd1,    16'd0,  16'hFFF7, 16'h0056, 7);
    check("held_done_rises", 16'(done_rises - rises0), 16'd1);
    run_op(3'b001, 5'd7, 5'd0, 5'd0, 16'd0,    16'h0056, 16'hFFF7, 16'h0056, 0);

    // 6b. reset during EXEC of ADD R8 = R1 + R1
    @(negedge clk);
    instr    = {3'b101, 5'd1, 5'd1, 5'd8, 16'd0};
    instr_en = 1'b1;
    repeat (2) @(negedge clk);   // capture edge, operand edge -> now in EXEC
    check("exec_busy", {15'b0, busy}, 16'd1);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    instr_en = 1'b0;
    check("rexec_done", {15'b0, done}, 16'd0);
    check("rexec_busy", {15'b0, busy}, 16'd0);
    check("rexec_do1", data_out1, 16'd0);
    check("rexec_do2", data_out2, 16'd0);
    check("rexec_do3", data_out3, 16'd0);
    run_op(3'b010, 5'd8, 5'd7, 5'd0, 16'd0,    16'd0,  16'd0, 16'd0, 0);

    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
